// File: rtl/shift_add_multiplier_ctrl.sv
// Shift-and-add sequencer for an unsigned 4x4 -> 8-bit multiply.
// Drives an external combinational adder and captures its sum/carry on ADD edges.
module shift_add_multiplier_ctrl (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [3:0] mcand,
  input  logic [3:0] mplier,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_cin,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state;
  logic [OP_W-1:0]   m_reg;
  logic [OP_W-1:0]   a_reg;
  logic [OP_W-1:0]   q_reg;
  logic              c_reg;
  logic [CNT_W-1:0]  cnt;

  // Operands come straight from registers in every state.
  assign add_a   = a_reg;
  assign add_b   = m_reg;
  assign add_cin = 1'b0;
  assign busy    = (state != IDLE);

  // Sequencer, datapath registers and result capture.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      c_reg   <= 1'b0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= mcand;
            q_reg <= mplier;
            a_reg <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          if (q_reg[0]) begin
            c_reg <= add_cout;
            a_reg <= add_sum;
          end else begin
            c_reg <= 1'b0;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          // {C,A,Q} shifts right one place; C refills with zero.
          a_reg <= {c_reg, a_reg[OP_W-1:1]};
          q_reg <= {a_reg[0], q_reg[OP_W-1:1]};
          c_reg <= 1'b0;
          if (cnt == CNT_W'(3)) begin
            product <= {c_reg, a_reg, q_reg[OP_W-1:1]};
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= ADD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
